ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 74 +++++++
 tb/tb_ifetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential PC fetcher feeding a small in-order instruction queue.
// Define FETCH_HALT_EN to stop fetching once a syscall (32'h0000_000C) has been queued.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [5:0]  imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [31:0]   fpc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop, push;
    assign imem_a    = fpc[7:2];
    assign out_valid = count != '0;
    assign out_instr = out_valid ? q_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? q_pc[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;
    assign push      = !redirect && !halted && (count < FULL || pop);
    // A redirect still honours a same-cycle pop; the flush simply wipes whatever remains.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            fpc    <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            fpc    <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fpc    <= fpc + 32'd4;
                wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push) begin
            q_pc[wr_ptr]    <= fpc;
            q_instr[wr_ptr] <= imem_rd;
        end
`ifdef FETCH_HALT_EN
    logic halt_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            halt_q <= 1'b0;
        else if (redirect)
            halt_q <= 1'b0;
        else if (push && imem_rd == 32'h0000_000C)
            halt_q <= 1'b1;
    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_ifetch_queue;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, halted;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd, out_instr, out_pc;
    logic [31:0] mem [64];
    int          tests = 0;
    int          fails = 0;
    ent_t        mq[$];
    logic [31:0] mfpc = RESET_PC;
    logic        mhalt = 1'b0;

    always #5 clk = ~clk;
    assign imem_rd = mem[imem_a];

    ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds exactly what the consumer should see, in order.
    always @(posedge clk) if (reset_n) begin
        bit   pop, push;
        ent_t e;
        pop  = mq.size() != 0 && out_ready;
        push = !redirect && !mhalt && (mq.size() < DEPTH || pop);
        if (pop) void'(mq.pop_front());
        if (redirect) begin
            mq.delete();
            mfpc  = {redirect_pc[31:2], 2'b00};
            mhalt = 1'b0;
        end else if (push) begin
            e.pc    = mfpc;
            e.instr = mem[mfpc[7:2]];
            mq.push_back(e);
`ifdef FETCH_HALT_EN
            if (e.instr == 32'h0000_000C) mhalt = 1'b1;
`endif
            mfpc = mfpc + 32'd4;
        end
    end

    // Monitor: compare the DUT's presented head against the scoreboard every cycle.
    always @(negedge clk) if (reset_n) begin
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
        end else begin
            chk("empty_pc", out_pc, 0);
            chk("empty_instr", out_instr, 0);
        end
        chk("imem_a", imem_a, mfpc[7:2]);
        chk("halted", halted, mhalt);
    end

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        #1;
        reset_n   = 1'b0;
        redirect  = 1'b0;
        out_ready = rdy;
        mq.delete();
        mfpc  = RESET_PC;
        mhalt = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_pc", out_pc, 0);
        @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == 32'h0000_000C) mem[i] = 32'h0000_0013;
        end
        mem[0] = 32'h2002_0005;
        mem[1] = 32'h2003_000C;
        mem[4] = 32'h0000_000C;
        @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_imem_a", imem_a, RESET_PC[7:2]);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("first_pc", out_pc, 32'h0);
        chk("first_instr", out_instr, 32'h2002_0005);
        @(negedge clk);
        chk("second_pc", out_pc, 32'h4);
        chk("second_instr", out_instr, 32'h2003_000C);
        @(negedge clk);
        chk("third_pc", out_pc, 32'h8);
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        chk("stall_imem_a", imem_a, 6'h02);
        chk("stall_head_pc", out_pc, 32'h0);
        chk("stall_valid", out_valid, 1);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("drain_pc4", out_pc, 32'h4);
        @(negedge clk);
        chk("drain_pc8", out_pc, 32'h8);
        @(negedge clk);
        chk("drain_pc12", out_pc, 32'hC);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0033;
        @(negedge clk);
        chk("redirect_flush_valid", out_valid, 0);
        chk("redirect_imem_a", imem_a, 6'h0C);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("redirect_target_pc", out_pc, 32'h30);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_imem_a_hi", imem_a, 6'h3F);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
        chk("wrap_imem_a_lo", imem_a, 6'h00);
        @(negedge clk);
        chk("wrap_pc_zero", out_pc, 32'h0);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        do_reset(1'b1);
        @(negedge clk);
        chk("post_reset_pc", out_pc, RESET_PC);
`ifdef FETCH_HALT_EN
        repeat (12) @(negedge clk);
        chk("halt_set", halted, 1);
        chk("halt_no_valid", out_valid, 0);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        chk("halt_cleared", halted, 0);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("halt_resume_pc", out_pc, 32'h0);
`endif
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                @(negedge clk);
                #1;
                out_ready   = $urandom_range(0, 9) < 7;
                redirect    = $urandom_range(0, 15) == 0;
                redirect_pc = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom;
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
